// File: rtl/des_ctrl_pkg.sv
// Shared types and constants for the DES round sequencer.
package des_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Left-rotation amount per encrypt round, element [i] belongs to round i.
    // Written from round 15 down to round 0.
    localparam logic [15:0][1:0] ROT_SCHED_ENC = {
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
        2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
    };

endpackage

// File: rtl/des_rot_sched.sv
// Key-rotation lookup: (round index, mode) -> rotation amount.
module des_rot_sched
    import des_ctrl_pkg::*;
(
    input  logic [3:0] round_idx,
    input  logic       mode,
    output logic [1:0] key_rot_amt
);

    logic [3:0] mirror_idx;

    // Decrypt walks the encrypt table backwards (index 16-i); round 0 is unrotated
    // because PC1 already leaves the key where the last encrypt round ended.
    always_comb begin
        mirror_idx = 4'd0 - round_idx;
        if (mode == MODE_DEC) begin
            key_rot_amt = (round_idx == 4'd0) ? 2'd0 : ROT_SCHED_ENC[mirror_idx];
        end else begin
            key_rot_amt = ROT_SCHED_ENC[round_idx];
        end
    end

endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES round sequencer: load, 16 round slots, final permutation,
// then a held result-valid handshake.
//
// state | meaning
// IDLE  | waiting for a start handshake
// LOAD  | one cycle, data and key load strobes
// ROUND | one slot of SBOX_LAT+1 cycles per round, round_en on the last cycle
// FINAL | one cycle, final permutation strobe
// DONE  | out_valid held until out_ready
module des_round_ctrl
    import des_ctrl_pkg::*;
#(
    parameter int ROUNDS   = 16,
    parameter int SBOX_LAT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic       mode,
    input  logic       abort,
    output logic       load_data,
    output logic       key_load,
    output logic       round_en,
    output logic [3:0] round_idx,
    output logic [1:0] key_rot_amt,
    output logic       key_rot_dir,
    output logic       final_en,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam int                WAIT_W     = (SBOX_LAT > 0) ? $clog2(SBOX_LAT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(SBOX_LAT);
    localparam logic [3:0]        ROUND_LAST = 4'(ROUNDS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mode_q;
    logic              slot_last;

    assign slot_last = (wait_cnt == WAIT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Round index, slot wait counter and mode latch; counters are zero outside ROUND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_idx <= 4'd0;
            wait_cnt  <= '0;
            mode_q    <= MODE_ENC;
        end else begin
            if ((state == IDLE) && start_valid && start_ready) begin
                mode_q <= mode;
            end
            if (abort || (state != ROUND)) begin
                round_idx <= 4'd0;
                wait_cnt  <= '0;
            end else if (slot_last) begin
                wait_cnt  <= '0;
                round_idx <= (round_idx == ROUND_LAST) ? 4'd0 : round_idx + 4'd1;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Next-state logic; abort wins over everything outside IDLE.
    always_comb begin
        state_nxt = state;
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_valid && start_ready) state_nxt = LOAD;
                LOAD:    state_nxt = ROUND;
                ROUND:   if (slot_last && (round_idx == ROUND_LAST)) state_nxt = FINAL;
                FINAL:   state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs decoded from state; strobes are suppressed in an abort cycle.
    always_comb begin
        start_ready = (state == IDLE) && !abort;
        load_data   = (state == LOAD) && !abort;
        key_load    = (state == LOAD) && !abort;
        round_en    = (state == ROUND) && slot_last && !abort;
        final_en    = (state == FINAL) && !abort;
        out_valid   = (state == DONE);
        busy        = (state != IDLE);
        key_rot_dir = (state != IDLE) && mode_q;
    end

    des_rot_sched u_rot_sched (
        .round_idx   (round_idx),
        .mode        (mode_q),
        .key_rot_amt (key_rot_amt)
    );

endmodule

// File: doc/des_round_ctrl.md
Name: des_round_ctrl

Overview:
- Iterative-mode sequencer for the DES round datapath: expansion, key XOR, the 8-way S-box stage, then P-permutation.
- Accepts a start request and drives the data and key load strobes.
- Steps 16 round-enable strobes with per-round key-rotation amount and direction, then the final-permutation strobe.
- Holds a result-valid handshake until it is consumed.
- Sits between the serial-interface command logic and a single shared round datapath, so one S-box instance serves all 16 rounds.

Parameters:
- ROUNDS, 16: round count; the schedule table is defined for 16 only.
- SBOX_LAT, 0: extra register stages in the round datapath; each round slot lasts SBOX_LAT+1 cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start_valid  in  1  request to process the block currently presented.
- start_ready  out  1  controller can accept a start.
- mode  in  1  0=encrypt, 1=decrypt; sampled on start handshake.
- abort  in  1  synchronous cancel.
- load_data  out  1  one-cycle strobe: datapath latches IP(plaintext) into L/R.
- key_load  out  1  one-cycle strobe: key register latches PC1(key).
- round_en  out  1  one-cycle strobe: datapath commits the round result.
- round_idx  out  4  current round, 0..15.
- key_rot_amt  out  2  rotation for this round (0, 1 or 2).
- key_rot_dir  out  1  0=left (encrypt), 1=right (decrypt); equals latched mode.
- final_en  out  1  one-cycle strobe: swap R16/L16 and apply IP^-1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, round_idx=0, wait counter=0, mode_q=0. All strobes and out_valid are 0; busy=0.
- start_ready = (state==IDLE) && !abort. It is combinational, so it reads 1 immediately after reset.
- States:
  - IDLE: on start_valid && start_ready, latch mode, go to LOAD.
  - LOAD: exactly 1 cycle. load_data=1, key_load=1. Go to ROUND with round_idx=0, wait counter=0.
  - ROUND: one slot per round of SBOX_LAT+1 cycles.
    - round_idx and key_rot_amt are stable for the whole slot.
    - round_en=1 only in the last cycle of the slot, then round_idx increments.
    - After the slot with round_idx=15, go to FINAL. round_idx returns to 0 and never wraps mid-operation.
  - FINAL: 1 cycle, final_en=1. Go to DONE.
  - DONE: out_valid=1 until out_ready is sampled high, then IDLE. out_ready while not in DONE is ignored.
- Latency: out_valid first asserts 3 + ROUNDS*(SBOX_LAT+1) cycles after the handshake cycle (19 for defaults). Back-to-back throughput is one block per latency+1 cycles when out_ready is tied high.
- Rotation schedule, encrypt (left), index 0..15: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Total 28.
- Rotation schedule, decrypt (right):
  - index 0: 0; index i≥1: the encrypt value at index 16-i.
  - Sequence: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Total 27.
- Key datapath: rotates by key_rot_amt coincident with round_en. The encrypt rotation applies before the round's subkey is used; the datapath owns that ordering.
- key_rot_dir = mode_q in all non-IDLE states; 0 in IDLE.
- abort, any non-IDLE state: next state is IDLE. No strobe fires in the abort cycle. round_idx and the wait counter clear, out_valid drops.
- abort in IDLE: no effect except masking start_ready.
- abort together with out_ready in DONE: result is treated as consumed; next state is IDLE either way.
- Reset mid-operation: immediate return to the reset values, with no strobes.
- start_valid while busy: ignored. The requester holds it until start_ready.

Decomposition:
- Package des_ctrl_pkg holds:
  - state enum (IDLE, LOAD, ROUND, FINAL, DONE);
  - ROT_SCHED_ENC constant (16 x 2-bit);
  - mode encoding constants.
- Sub-module des_rot_sched: combinational lookup (round_idx, mode) -> key_rot_amt. It is unit-tested separately.

Test Plan:
- Encrypt, defaults: start pulse with mode=0, out_ready=1.
  - load_data/key_load in cycle 1; 16 round_en pulses in cycles 2..17; final_en in cycle 18; out_valid in cycle 19.
  - Sum of key_rot_amt over the round_en cycles = 28; key_rot_dir=0.
- Decrypt: mode=1. Captured key_rot_amt sequence = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 27); key_rot_dir=1 throughout.
- SBOX_LAT=2: round_en every 3rd cycle; round_idx stable for 3 cycles each; out_valid at cycle 51.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - out_valid stays high and start_ready stays 0.
  - A start_valid asserted meanwhile is accepted only in the first IDLE cycle.
- Abort at round_idx=7: next cycle state=IDLE, busy=0, round_idx=0, no round_en or final_en. A new start then completes normally with 19-cycle latency.
- Async reset pulse mid-ROUND (between clock edges): all outputs drop immediately, start_ready=1, and the first post-reset start runs cleanly.
